// File: rtl/frame_scheduler_if.sv
// Start/done handshake bundle between the frame sequencer (master) and the
// erase/update/draw render units (slave).
interface frame_scheduler_if;
  logic erase_start;
  logic update_start;
  logic draw_start;
  logic busy;
  logic erase_done;
  logic update_done;
  logic draw_done;

  modport master (
    output erase_start, update_start, draw_start, busy,
    input  erase_done, update_done, draw_done
  );

  modport slave (
    input  erase_start, update_start, draw_start, busy,
    output erase_done, update_done, draw_done
  );
endinterface

// File: rtl/frame_scheduler.sv
// Game time base: divides the board clock into frame ticks, sequences
// erase -> update -> draw once per frame, and keeps a BCD seconds timer.
module frame_scheduler #(
  parameter int unsigned FRAME_DIV      = 1666667,
  parameter int unsigned FRAMES_PER_SEC = 30
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic               clear,
  frame_scheduler_if.master  render,
  output logic               frame_tick,
  output logic               sec_tick,
  output logic [4:0]         frame_count,
  output logic [3:0]         dig0,
  output logic [3:0]         dig1,
  output logic [3:0]         dig2,
  output logic [3:0]         dig3,
  output logic               overrun
);

  localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [1:0] {Idle, Erase, Update, Draw} state_t;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]      frame_cnt_q, frame_cnt_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic            carry;
  state_t          state_q;
  logic            erase_start_q, update_start_q, draw_start_q;
  logic            overrun_q;
  logic            draw_accept;

  assign frame_tick = enable && (div_cnt_q == DivW'(FRAME_DIV - 1));
  assign sec_tick   = frame_tick && (frame_cnt_q == 5'(FRAMES_PER_SEC - 1));

  // Done inputs are ignored in the start cycle of their state.
  assign draw_accept = (state_q == Draw) && !draw_start_q && render.draw_done;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (enable) begin
      div_cnt_d = frame_tick ? '0 : div_cnt_q + DivW'(1);
    end
    frame_cnt_d = frame_cnt_q;
    if (sec_tick) begin
      frame_cnt_d = '0;
    end else if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 5'd1;
    end
    // clear has priority over a coincident seconds increment.
    dig_d = dig_q;
    carry = 1'b1;
    if (clear) begin
      dig_d = '0;
    end else if (sec_tick) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (dig_q[i] == 4'd9) begin
            dig_d[i] = 4'd0;
          end else begin
            dig_d[i] = dig_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      div_cnt_q   <= '0;
      frame_cnt_q <= '0;
      dig_q       <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      dig_q       <= dig_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= Idle;
      erase_start_q  <= 1'b0;
      update_start_q <= 1'b0;
      draw_start_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      erase_start_q  <= 1'b0;
      update_start_q <= 1'b0;
      draw_start_q   <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (frame_tick) begin
            state_q       <= Erase;
            erase_start_q <= 1'b1;
          end
        end
        Erase: begin
          if (!erase_start_q && render.erase_done) begin
            state_q        <= Update;
            update_start_q <= 1'b1;
          end
        end
        Update: begin
          if (!update_start_q && render.update_done) begin
            state_q      <= Draw;
            draw_start_q <= 1'b1;
          end
        end
        Draw: begin
          if (draw_accept) begin
            state_q       <= frame_tick ? Erase : Idle;
            erase_start_q <= frame_tick;
          end
        end
        default: state_q <= Idle;
      endcase
      // A tick that cannot start a new sequence is dropped and flagged.
      if (clear) begin
        overrun_q <= 1'b0;
      end else if (frame_tick && (state_q != Idle) && !draw_accept) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign render.erase_start  = erase_start_q;
  assign render.update_start = update_start_q;
  assign render.draw_start   = draw_start_q;
  assign render.busy         = (state_q != Idle);
  assign frame_count         = frame_cnt_q;
  assign dig0                = dig_q[0];
  assign dig1                = dig_q[1];
  assign dig2                = dig_q[2];
  assign dig3                = dig_q[3];
  assign overrun             = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: a cycle-level reference model built
// from phase/age bookkeeping and integer seconds, plus a fast second instance for timer wrap.
module tb_frame_scheduler;

  localparam int FrameDiv = 4;
  localparam int Fps      = 3;

  logic clock = 1'b0;
  logic resetn, enable, clear;
  logic eraseDone, updateDone, drawDone;
  logic resetn2, enable2, clear2;
  logic frameTick, secTick, overrun;
  logic [4:0] frameCount;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic frameTick2, secTick2, overrun2;
  logic [4:0] frameCount2;
  logic [3:0] d20, d21, d22, d23;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state: phase 0 idle, 1 erase, 2 update, 3 draw; age = cycles spent in phase.
  int mDiv, mFrames, mSecs, mPhase, mAge, mNext;
  logic mOverrun, mt, ms, mAcc;

  always #5 clock = ~clock;

  frame_scheduler_if ifc ();
  frame_scheduler_if if2 ();

  assign ifc.erase_done  = eraseDone;
  assign ifc.update_done = updateDone;
  assign ifc.draw_done   = drawDone;
  assign if2.erase_done  = 1'b1;
  assign if2.update_done = 1'b1;
  assign if2.draw_done   = 1'b1;

  frame_scheduler #(.FRAME_DIV(FrameDiv), .FRAMES_PER_SEC(Fps)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .clear(clear), .render(ifc.master),
    .frame_tick(frameTick), .sec_tick(secTick), .frame_count(frameCount),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .overrun(overrun)
  );

  frame_scheduler #(.FRAME_DIV(2), .FRAMES_PER_SEC(1)) dut2 (
    .clock(clock), .resetn(resetn2), .enable(enable2), .clear(clear2), .render(if2.master),
    .frame_tick(frameTick2), .sec_tick(secTick2), .frame_count(frameCount2),
    .dig0(d20), .dig1(d21), .dig2(d22), .dig3(d23), .overrun(overrun2)
  );

  function automatic logic doneFor(int p);
    return (p == 1) ? eraseDone : (p == 2) ? updateDone : drawDone;
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      mDiv = 0; mFrames = 0; mSecs = 0; mPhase = 0; mAge = 0; mOverrun = 1'b0;
    end else begin
      mt   = enable && (mDiv == FrameDiv - 1);
      ms   = mt && (mFrames == Fps - 1);
      mAcc = (mPhase != 0) && (mAge > 0) && doneFor(mPhase);
      if (enable) mDiv = (mDiv + 1) % FrameDiv;
      if (mt) mFrames = (mFrames + 1) % Fps;
      if (clear) begin
        mSecs = 0;
        mOverrun = 1'b0;
      end else begin
        if (ms) mSecs = (mSecs + 1) % 10000;
        if (mt && mPhase != 0 && !(mPhase == 3 && mAcc)) mOverrun = 1'b1;
      end
      if (mPhase == 0) mNext = mt ? 1 : 0;
      else if (mAcc) mNext = (mPhase == 3) ? (mt ? 1 : 0) : mPhase + 1;
      else mNext = mPhase;
      mAge   = (mNext != mPhase) ? 0 : mAge + 1;
      mPhase = mNext;
    end
  end

  function automatic logic [27:0] expVec();
    logic t, s;
    t = enable && (mDiv == FrameDiv - 1);
    s = t && (mFrames == Fps - 1);
    return {mPhase == 1 && mAge == 0, mPhase == 2 && mAge == 0, mPhase == 3 && mAge == 0,
            mPhase != 0, t, s, 5'(mFrames), 4'(mSecs / 1000 % 10), 4'(mSecs / 100 % 10),
            4'(mSecs / 10 % 10), 4'(mSecs % 10), mOverrun};
  endfunction

  function automatic logic [27:0] obsVec();
    return {ifc.erase_start, ifc.update_start, ifc.draw_start, ifc.busy, frameTick, secTick,
            frameCount, dig3, dig2, dig1, dig0, overrun};
  endfunction

  function automatic logic [15:0] bcdOf(int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic applyReset();
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; clear = 1'b0;
    eraseDone = 1'b1; updateDone = 1'b1; drawDone = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      testsRun++;
      if (obsVec() !== 28'h0) begin
        testsFailed++;
        $display("[TB] FAIL reset cycle %0d: got %h want %h", c, obsVec(), 28'h0);
      end
    end
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int tickAt = -1, eraseAt = -1, updAt = -1, drawAt = -1;
    enable = 1'b1; clear = 1'b0;
    eraseDone = 1'b1; updateDone = 1'b1; drawDone = 1'b1;
    applyReset();
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      testsRun++;
      if (obsVec() !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL basic cycle %0d: got %h want %h", c, obsVec(), expVec());
      end
      if (frameTick && tickAt < 0) tickAt = c;
      if (ifc.erase_start && eraseAt < 0) eraseAt = c;
      if (ifc.update_start && updAt < 0) updAt = c;
      if (ifc.draw_start && drawAt < 0) drawAt = c;
      @(posedge clock); #1;
    end
    testsRun++;
    if (tickAt !== 3) begin
      testsFailed++;
      $display("[TB] FAIL basic first_tick: got %0d want 3", tickAt);
    end
    testsRun++;
    if ({eraseAt - tickAt, updAt - tickAt, drawAt - tickAt} !== {32'sd1, 32'sd3, 32'sd5}) begin
      testsFailed++;
      $display("[TB] FAIL basic start_latency: got %0d/%0d/%0d want 1/3/5",
               eraseAt - tickAt, updAt - tickAt, drawAt - tickAt);
    end
  endtask

  task automatic test_seconds();
    int secs = 0;
    enable = 1'b1; clear = 1'b0;
    eraseDone = 1'b1; updateDone = 1'b1; drawDone = 1'b1;
    applyReset();
    for (int c = 0; c < 12 * FrameDiv; c++) begin
      @(negedge clock);
      testsRun++;
      if (obsVec() !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL seconds cycle %0d: got %h want %h", c, obsVec(), expVec());
      end
      if (secTick) begin
        secs++;
        testsRun++;
        if (!frameTick || frameCount !== 5'(Fps - 1)) begin
          testsFailed++;
          $display("[TB] FAIL seconds wrap_point: got tick=%b count=%0d want tick=1 count=%0d",
                   frameTick, frameCount, Fps - 1);
        end
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    testsRun++;
    if (secs !== 4 || {dig3, dig2, dig1, dig0} !== 16'h0004) begin
      testsFailed++;
      $display("[TB] FAIL seconds after_12_frames: got %0d ticks digits %h want 4 ticks digits 0004",
               secs, {dig3, dig2, dig1, dig0});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_overrun();
    int erases = 0;
    enable = 1'b1; clear = 1'b0;
    eraseDone = 1'b1; updateDone = 1'b0; drawDone = 1'b1;
    applyReset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      testsRun++;
      if (obsVec() !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL overrun cycle %0d: got %h want %h", c, obsVec(), expVec());
      end
      if (ifc.erase_start) erases++;
      @(posedge clock); #1;
    end
    testsRun++;
    if (overrun !== 1'b1 || erases !== 1) begin
      testsFailed++;
      $display("[TB] FAIL overrun stuck_update: got overrun=%b erases=%0d want overrun=1 erases=1",
               overrun, erases);
    end
    updateDone = 1'b1; clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    testsRun++;
    if (overrun !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL overrun clear: got %b want 0", overrun);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    enable = 1'b1; clear = 1'b0;
    eraseDone = 1'b1; updateDone = 1'b1; drawDone = 1'b0;
    applyReset();
    for (int c = 0; c < 40 && !found; c++) begin
      if (mPhase == 3 && mAge >= 1 && !(mDiv == FrameDiv - 1)) found = 1;
      else begin
        @(negedge clock);
        testsRun++;
        if (obsVec() !== expVec()) begin
          testsFailed++;
          $display("[TB] FAIL b2b cycle %0d: got %h want %h", c, obsVec(), expVec());
        end
        @(posedge clock); #1;
      end
    end
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      if (mDiv == FrameDiv - 1 && mPhase == 3) found = 1;
      else begin
        @(posedge clock); #1;
      end
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL b2b timeout: got no tick in DRAW want one within 8 cycles");
    end
    drawDone = 1'b1;
    @(negedge clock);
    testsRun++;
    if (obsVec() !== expVec()) begin
      testsFailed++;
      $display("[TB] FAIL b2b coincident: got %h want %h", obsVec(), expVec());
    end
    @(posedge clock); #1;
    drawDone = 1'b0;
    @(negedge clock);
    testsRun++;
    if ({ifc.erase_start, ifc.busy, overrun} !== 3'b110) begin
      testsFailed++;
      $display("[TB] FAIL b2b restart: got start/busy/ovr=%b%b%b want 110",
               ifc.erase_start, ifc.busy, overrun);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_enable_off();
    int frozen = 0, ticks = 0;
    bit found = 0;
    enable = 1'b1; clear = 1'b0;
    eraseDone = 1'b0; updateDone = 1'b1; drawDone = 1'b1;
    applyReset();
    for (int c = 0; c < 20 && !found; c++) begin
      if (mPhase == 1) found = 1;
      else begin
        @(posedge clock); #1;
      end
    end
    frozen = mDiv;
    enable = 1'b0; eraseDone = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      testsRun++;
      if (obsVec() !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL enable_off cycle %0d: got %h want %h", c, obsVec(), expVec());
      end
      if (frameTick) ticks++;
      @(posedge clock); #1;
    end
    @(negedge clock);
    testsRun++;
    if (ifc.busy !== 1'b0 || ticks !== 0 || int'(dut.div_cnt_q) !== frozen) begin
      testsFailed++;
      $display("[TB] FAIL enable_off hold: got busy=%b ticks=%0d div=%0d want busy=0 ticks=0 div=%0d",
               ifc.busy, ticks, dut.div_cnt_q, frozen);
    end
    @(posedge clock); #1;
    enable = 1'b1; drawDone = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (mPhase == 3) found = 1;
      else begin
        @(posedge clock); #1;
      end
    end
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    testsRun++;
    if (!found || obsVec() !== 28'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_draw: got %h (reached draw=%0d) want %h", obsVec(), found, 28'h0);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    clear = 1'b0;
    applyReset();
    for (int c = 0; c < 1500; c++) begin
      enable     = ($urandom_range(0, 9) != 0);
      eraseDone  = ($urandom_range(0, 2) == 0);
      updateDone = ($urandom_range(0, 2) == 0);
      drawDone   = ($urandom_range(0, 1) == 0);
      clear      = ($urandom_range(0, 39) == 0);
      resetn     = ($urandom_range(0, 299) != 0);
      @(negedge clock);
      testsRun++;
      if (obsVec() !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL random cycle %0d: got %h want %h", c, obsVec(), expVec());
      end
      @(posedge clock); #1;
    end
    resetn = 1'b1; clear = 1'b0;
  endtask

  task automatic test_wrap();
    int secCount = 0;
    bit pending = 0;
    bit done = 0;
    enable2 = 1'b1; clear2 = 1'b0; resetn2 = 1'b0;
    @(posedge clock); #1;
    resetn2 = 1'b1;
    for (int c = 0; c < 25000 && !done; c++) begin
      @(negedge clock);
      if (pending) begin
        pending = 0;
        testsRun++;
        if ({d23, d22, d21, d20} !== bcdOf(secCount % 10000)) begin
          testsFailed++;
          $display("[TB] FAIL wrap digits after %0d sec: got %h want %h",
                   secCount, {d23, d22, d21, d20}, bcdOf(secCount % 10000));
        end
        if (secCount == 10001) done = 1;
      end
      if (!done && secTick2) begin
        secCount++;
        pending = 1;
      end
      if (!done) begin
        @(posedge clock); #1;
      end
    end
    testsRun++;
    if (!done) begin
      testsFailed++;
      $display("[TB] FAIL wrap timeout: got %0d sec ticks want 10001", secCount);
    end
    done = 0;
    for (int c = 0; c < 8 && !done; c++) begin
      if (secTick2) begin
        clear2 = 1'b1;
        done = 1;
      end
      @(posedge clock); #1;
      if (!done) @(negedge clock);
    end
    clear2 = 1'b0;
    @(negedge clock);
    testsRun++;
    if (!done || {d23, d22, d21, d20} !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL wrap clear_beats_tick: got %h (saw tick=%0d) want 0000",
               {d23, d22, d21, d20}, done);
    end
    enable2 = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; clear = 1'b0;
    eraseDone = 1'b0; updateDone = 1'b0; drawDone = 1'b0;
    resetn2 = 1'b0; enable2 = 1'b0; clear2 = 1'b0;
    test_reset();
    test_basic();
    test_seconds();
    test_overrun();
    test_back_to_back();
    test_enable_off();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
